db_affine_buffer: RTL and testbench

//   Parametrised double-buffered memory core. The write side fills one bank sequentially.
//   The read side drains the other bank in an N-dimensional affine pattern
//   (start + sum idx_d*stride_d). Banks swap when both sides finish.

---
 rtl/db_affine_buffer_if.sv | 23 ++
 rtl/db_affine_buffer.sv | 148 ++++++++++++++
 tb/tb_db_affine_buffer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_affine_buffer_if.sv
// Write/read handshake bundle for db_affine_buffer.
// The master side is the producer/consumer; the slave side is the buffer.
interface db_affine_buffer_if #(
  parameter int DATA_W = 16
);
  logic              wen_in;
  logic [DATA_W-1:0] data_in;
  logic              wr_ready;
  logic              ren_in;
  logic              rd_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    output wen_in, data_in, ren_in,
    input  wr_ready, rd_ready, data_out, valid_out
  );

  modport slave (
    input  wen_in, data_in, ren_in,
    output wr_ready, rd_ready, data_out, valid_out
  );
endinterface

// File: rtl/db_affine_buffer.sv
// Double-buffered memory: sequential fill of one bank while the other drains
// in an N-dimensional affine pattern; banks swap when both sides finish.
module db_affine_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int NDIM   = 4,
  parameter int CFG_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  db_affine_buffer_if.slave     bus,
  input  logic [CFG_W-1:0]      depth_cfg,
  input  logic [2:0]            dimensionality,
  input  logic [CFG_W-1:0]      starting_addr,
  input  logic [NDIM*CFG_W-1:0] stride,
  input  logic [NDIM*CFG_W-1:0] range,
  output logic [1:0]            state_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CFG_W + AW;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nx;
  logic              wbank, rbank;
  logic [CFG_W-1:0]  wr_cnt;
  logic [CFG_W-1:0]  idx      [NDIM];
  logic [CFG_W-1:0]  idx_nx   [NDIM];
  logic [2:0]        dim_q;
  logic [CFG_W-1:0]  start_q;
  logic [CFG_W-1:0]  stride_q [NDIM];
  logic [CFG_W-1:0]  range_q  [NDIM];
  logic [DATA_W-1:0] mem      [2*DEPTH];

  logic              wr_acc, rd_acc, wr_done, rd_done, rd_last, swap, carry;
  logic [NDIM-1:0]   act;
  logic [AW-1:0]     rd_addr;

  assign wr_acc  = clk_en & bus.wen_in & bus.wr_ready;
  assign rd_acc  = clk_en & bus.ren_in & bus.rd_ready;
  assign wr_done = wr_acc & (wr_cnt == depth_cfg - CFG_W'(1));
  assign rd_done = rd_acc & rd_last;
  assign swap    = (wr_done & ((state == IDLE) | ((state == READ) & rd_done)))
                 | ((state == FULL) & rd_done);

  // Products are formed at SW bits; only the low AW bits reach the address.
  always_comb begin
    rd_addr = AW'(start_q);
    rd_last = 1'b1;
    act     = '0;
    for (int unsigned d = 0; d < NDIM; d++) begin
      act[d] = (d < 32'(dim_q));
      if (act[d]) begin
        rd_addr = rd_addr + AW'(SW'(idx[d]) * SW'(stride_q[d]));
        if (idx[d] != range_q[d] - CFG_W'(1)) rd_last = 1'b0;
      end
    end
  end

  // Odometer: innermost dimension first, carry ripples outward.
  always_comb begin
    idx_nx = idx;
    carry  = 1'b1;
    if (rd_done) begin
      for (int unsigned d = 0; d < NDIM; d++) idx_nx[d] = '0;
    end else if (rd_acc) begin
      for (int unsigned d = 0; d < NDIM; d++) begin
        if (act[d] && carry) begin
          if (idx[d] == range_q[d] - CFG_W'(1)) begin
            idx_nx[d] = '0;
          end else begin
            idx_nx[d] = idx[d] + CFG_W'(1);
            carry     = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (wr_done) state_nx = READ;
      READ: begin
        if (wr_done && rd_done) state_nx = READ;
        else if (wr_done)       state_nx = FULL;
        else if (rd_done)       state_nx = IDLE;
      end
      FULL: if (rd_done) state_nx = READ;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready = (state != FULL);
    bus.rd_ready = (state != IDLE);
    state_out    = state;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wr_cnt        <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      dim_q         <= '0;
      start_q       <= '0;
      for (int unsigned d = 0; d < NDIM; d++) begin
        idx[d]      <= '0;
        stride_q[d] <= '0;
        range_q[d]  <= '0;
      end
    end else if (clk_en) begin
      bus.valid_out <= rd_acc;
      if (rd_acc) bus.data_out <= mem[{rbank, rd_addr}];
      idx <= idx_nx;
      if (swap) begin
        rbank   <= wbank;
        wbank   <= ~wbank;
        wr_cnt  <= '0;
        dim_q   <= dimensionality;
        start_q <= starting_addr;
        for (int unsigned d = 0; d < NDIM; d++) begin
          stride_q[d] <= stride[d*CFG_W +: CFG_W];
          range_q[d]  <= range[d*CFG_W +: CFG_W];
        end
      end else if (wr_acc) begin
        wr_cnt <= wr_cnt + CFG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2*DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc && !flush) begin
      mem[{wbank, wr_cnt[AW-1:0]}] <= bus.data_in;
    end
  end
endmodule

// File: tb/tb_db_affine_buffer.sv
// Bench for db_affine_buffer: directed scenarios plus random traffic against
// a tile-list reference model of the double buffer.
module tb_db_affine_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int NDIM   = 4;
  localparam int CFG_W  = 16;

  logic                  clk = 1'b0;
  logic                  reset, clk_en, flush;
  logic [CFG_W-1:0]      depth_cfg, starting_addr;
  logic [2:0]            dimensionality;
  logic [CFG_W-1:0]      cfg_stride [NDIM];
  logic [CFG_W-1:0]      cfg_range  [NDIM];
  logic [NDIM*CFG_W-1:0] stride, range;
  logic [1:0]            state_out;

  db_affine_buffer_if #(.DATA_W(DATA_W)) bus ();

  db_affine_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NDIM(NDIM), .CFG_W(CFG_W)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .bus(bus),
    .depth_cfg(depth_cfg), .dimensionality(dimensionality),
    .starting_addr(starting_addr), .stride(stride), .range(range),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    stride = '0;
    range  = '0;
    for (int d = 0; d < NDIM; d++) begin
      stride[d*CFG_W +: CFG_W] = cfg_stride[d];
      range[d*CFG_W +: CFG_W]  = cfg_range[d];
    end
  end

  // Reference model: each read tile is a precomputed list of addresses.
  int m_state, m_wbank, m_rbank, m_wcnt, m_data;
  bit m_valid;
  int m_bank [2][DEPTH];
  int m_dim, m_start;
  int m_stride [NDIM];
  int m_range  [NDIM];
  int m_addrq [$];
  int vectors = 0;
  int errors  = 0;

  function automatic void gen_tile();
    int total, rem, addr;
    m_addrq.delete();
    total = 1;
    for (int d = 0; d < m_dim; d++) total *= m_range[d];
    for (int n = 0; n < total; n++) begin
      rem  = n;
      addr = m_start;
      for (int d = 0; d < m_dim; d++) begin
        addr += (rem % m_range[d]) * m_stride[d];
        rem  /= m_range[d];
      end
      m_addrq.push_back(addr % DEPTH);
    end
  endfunction

  task automatic model_step();
    bit wacc, racc, wdone, rdone, sw;
    int a, nst;
    if (reset || flush) begin
      m_state = 0; m_wbank = 0; m_rbank = 0; m_wcnt = 0;
      m_valid = 0; m_data = 0;
      m_addrq.delete();
      if (reset) for (int b = 0; b < 2; b++) for (int i = 0; i < DEPTH; i++) m_bank[b][i] = 0;
    end else if (clk_en) begin
      wacc  = bus.wen_in && (m_state != 2);
      racc  = bus.ren_in && (m_state != 0);
      wdone = 0;
      rdone = 0;
      m_valid = racc;
      if (racc) begin
        a      = m_addrq.pop_front();
        m_data = m_bank[m_rbank][a];
        rdone  = (m_addrq.size() == 0);
      end
      if (wacc) begin
        m_bank[m_wbank][m_wcnt % DEPTH] = int'(bus.data_in);
        wdone = (m_wcnt == int'(depth_cfg) - 1);
        m_wcnt++;
      end
      sw = (m_state == 0 && wdone) || (m_state == 1 && wdone && rdone) || (m_state == 2 && rdone);
      nst = m_state;
      case (m_state)
        0: if (wdone) nst = 1;
        1: if (wdone && rdone) nst = 1; else if (wdone) nst = 2; else if (rdone) nst = 0;
        2: if (rdone) nst = 1;
        default: nst = 0;
      endcase
      m_state = nst;
      if (rdone) gen_tile();
      if (sw) begin
        m_rbank = m_wbank;
        m_wbank = 1 - m_wbank;
        m_wcnt  = 0;
        m_dim   = int'(dimensionality);
        m_start = int'(starting_addr);
        for (int d = 0; d < NDIM; d++) begin
          m_stride[d] = int'(cfg_stride[d]);
          m_range[d]  = int'(cfg_range[d]);
        end
        gen_tile();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int dep, input int dim, input int st,
                         input int s0, input int s1, input int s2, input int s3,
                         input int r0, input int r1, input int r2, input int r3);
    depth_cfg      = CFG_W'(dep);
    dimensionality = 3'(dim);
    starting_addr  = CFG_W'(st);
    cfg_stride[0] = CFG_W'(s0); cfg_stride[1] = CFG_W'(s1);
    cfg_stride[2] = CFG_W'(s2); cfg_stride[3] = CFG_W'(s3);
    cfg_range[0]  = CFG_W'(r0); cfg_range[1]  = CFG_W'(r1);
    cfg_range[2]  = CFG_W'(r2); cfg_range[3]  = CFG_W'(r3);
  endtask

  task automatic wr_word(input int v);
    bus.wen_in = 1'b1; bus.ren_in = 1'b0; bus.data_in = DATA_W'(v);
    tick();
    bus.wen_in = 1'b0;
  endtask

  task automatic rd_word();
    bus.ren_in = 1'b1; bus.wen_in = 1'b0;
    tick();
    bus.ren_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
    bus.wen_in = 1'b0; bus.ren_in = 1'b0; bus.data_in = '0;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if ({bus.valid_out, bus.wr_ready, bus.rd_ready} !== 3'b010 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctl: got valid/wr/rd=%b state=%0d, want 010 state=0",
               {bus.valid_out, bus.wr_ready, bus.rd_ready}, state_out);
    end
    vectors++;
    if (bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0d, want 0", bus.data_out);
    end
  endtask

  task automatic test_cube();
    set_cfg(27, 3, 0, 1, 3, 9, 0, 3, 3, 3, 1);
    for (int i = 0; i < 27; i++) begin
      wr_word(i);
      vectors++;
      if (state_out !== 2'((i == 26) ? 1 : 0)) begin
        errors++;
        $display("FAIL cube_wr_state%0d: got %0d, want %0d", i, state_out, (i == 26) ? 1 : 0);
      end
    end
    for (int i = 0; i < 27; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(i) ||
          state_out !== 2'((i == 26) ? 0 : 1)) begin
        errors++;
        $display("FAIL cube_rd%0d: got v=%b d=%0d st=%0d, want v=1 d=%0d st=%0d",
                 i, bus.valid_out, bus.data_out, state_out, i, (i == 26) ? 0 : 1);
      end
    end
    tick();
    vectors++;
    if (bus.valid_out !== 1'b0 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL cube_end: got v=%b st=%0d, want v=0 st=0", bus.valid_out, state_out);
    end
  endtask

  task automatic test_transpose();
    int tbl [9];
    tbl = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    set_cfg(9, 2, 0, 3, 1, 0, 0, 3, 3, 1, 1);
    for (int i = 0; i < 9; i++) wr_word(i);
    for (int i = 0; i < 9; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(tbl[i])) begin
        errors++;
        $display("FAIL transpose_rd%0d: got v=%b d=%0d, want v=1 d=%0d",
                 i, bus.valid_out, bus.data_out, tbl[i]);
      end
    end
  endtask

  task automatic test_full();
    set_cfg(9, 1, 0, 1, 0, 0, 0, 9, 1, 1, 1);
    for (int i = 0; i < 18; i++) begin
      wr_word(100 + i);
      vectors++;
      if (state_out !== 2'((i < 8) ? 0 : (i < 17) ? 1 : 2) || bus.wr_ready !== (i != 17)) begin
        errors++;
        $display("FAIL full_wr%0d: got st=%0d wr_ready=%b, want st=%0d wr_ready=%b",
                 i, state_out, bus.wr_ready, (i < 8) ? 0 : (i < 17) ? 1 : 2, i != 17);
      end
    end
    for (int i = 0; i < 18; i++) begin
      bus.ren_in = 1'b1; bus.wen_in = (i < 9); bus.data_in = DATA_W'(999);
      tick();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(100 + i) ||
          state_out !== 2'((i < 8) ? 2 : (i < 17) ? 1 : 0) || bus.wr_ready !== (i >= 8)) begin
        errors++;
        $display("FAIL full_rd%0d: got v=%b d=%0d st=%0d wr_ready=%b, want v=1 d=%0d st=%0d wr_ready=%b",
                 i, bus.valid_out, bus.data_out, state_out, bus.wr_ready, 100 + i,
                 (i < 8) ? 2 : (i < 17) ? 1 : 0, i >= 8);
      end
    end
    bus.ren_in = 1'b0; bus.wen_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_cfg(9, 1, 0, 1, 0, 0, 0, 9, 1, 1, 1);
    for (int i = 0; i < 9; i++) wr_word(200 + i);
    for (int i = 0; i < 18; i++) begin
      bus.ren_in = 1'b1; bus.wen_in = (i < 9); bus.data_in = DATA_W'(300 + i);
      tick();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'((i < 9) ? 200 + i : 291 + i) ||
          state_out !== 2'((i == 17) ? 0 : 1)) begin
        errors++;
        $display("FAIL b2b_rd%0d: got v=%b d=%0d st=%0d, want v=1 d=%0d st=%0d",
                 i, bus.valid_out, bus.data_out, state_out, (i < 9) ? 200 + i : 291 + i,
                 (i == 17) ? 0 : 1);
      end
    end
    bus.ren_in = 1'b0; bus.wen_in = 1'b0;
  endtask

  task automatic test_wrap();
    set_cfg(64, 1, 60, 1, 0, 0, 0, 8, 1, 1, 1);
    for (int i = 0; i < 64; i++) wr_word(500 + i);
    for (int i = 0; i < 8; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(500 + (60 + i) % 64)) begin
        errors++;
        $display("FAIL wrap_rd%0d: got v=%b d=%0d, want v=1 d=%0d",
                 i, bus.valid_out, bus.data_out, 500 + (60 + i) % 64);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; tick(); flush = 1'b0;
    set_cfg(64, 1, 0, 1, 0, 0, 0, 4, 1, 1, 1);
    for (int i = 0; i < 64; i++) wr_word(800 + i);
    rd_word();
    flush = 1'b1; tick(); flush = 1'b0;
    vectors++;
    if ({bus.valid_out, bus.wr_ready, bus.rd_ready} !== 3'b010 || state_out !== 2'd0 ||
        bus.data_out !== '0) begin
      errors++;
      $display("FAIL flush_ctl: got v/wr/rd=%b st=%0d d=%0d, want 010 st=0 d=0",
               {bus.valid_out, bus.wr_ready, bus.rd_ready}, state_out, bus.data_out);
    end
    set_cfg(4, 1, 20, 1, 0, 0, 0, 4, 1, 1, 1);
    for (int i = 0; i < 4; i++) wr_word(900 + i);
    for (int i = 0; i < 4; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(820 + i)) begin
        errors++;
        $display("FAIL flush_keep%0d: got v=%b d=%0d, want v=1 d=%0d",
                 i, bus.valid_out, bus.data_out, 820 + i);
      end
    end
  endtask

  task automatic test_reset_zero();
    reset = 1'b1; tick(); reset = 1'b0;
    set_cfg(4, 1, 10, 1, 0, 0, 0, 4, 1, 1, 1);
    for (int i = 0; i < 4; i++) wr_word(1 + i);
    for (int i = 0; i < 4; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== '0) begin
        errors++;
        $display("FAIL reset_zero%0d: got v=%b d=%0d, want v=1 d=0", i, bus.valid_out, bus.data_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(9, 1, 0, 1, 0, 0, 0, 9, 1, 1, 1);
    for (int i = 0; i < 9; i++) wr_word(40 + i);
    for (int i = 0; i < 4; i++) begin
      rd_word();
      vectors++;
      if (bus.data_out !== DATA_W'(40 + i)) begin
        errors++;
        $display("FAIL rstmid_rd%0d: got %0d, want %0d", i, bus.data_out, 40 + i);
      end
    end
    reset = 1'b1; bus.ren_in = 1'b1;
    tick();
    reset = 1'b0; bus.ren_in = 1'b0;
    vectors++;
    if ({bus.valid_out, bus.wr_ready, bus.rd_ready} !== 3'b010 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_ctl: got v/wr/rd=%b st=%0d, want 010 st=0",
               {bus.valid_out, bus.wr_ready, bus.rd_ready}, state_out);
    end
  endtask

  task automatic test_clk_en();
    set_cfg(9, 1, 0, 1, 0, 0, 0, 9, 1, 1, 1);
    for (int i = 0; i < 9; i++) wr_word(60 + i);
    for (int i = 0; i < 3; i++) rd_word();
    bus.ren_in = 1'b1; bus.wen_in = 1'b1; bus.data_in = DATA_W'(7777); clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({bus.valid_out, bus.wr_ready, bus.rd_ready} !== 3'b111 || state_out !== 2'd1 ||
          bus.data_out !== DATA_W'(62)) begin
        errors++;
        $display("FAIL clken_hold%0d: got v/wr/rd=%b st=%0d d=%0d, want 111 st=1 d=62",
                 i, {bus.valid_out, bus.wr_ready, bus.rd_ready}, state_out, bus.data_out);
      end
    end
    clk_en = 1'b1; bus.wen_in = 1'b0;
    for (int i = 3; i < 9; i++) begin
      rd_word();
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DATA_W'(60 + i) ||
          state_out !== 2'((i == 8) ? 0 : 1)) begin
        errors++;
        $display("FAIL clken_rd%0d: got v=%b d=%0d st=%0d, want v=1 d=%0d st=%0d",
                 i, bus.valid_out, bus.data_out, state_out, 60 + i, (i == 8) ? 0 : 1);
      end
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    depth_cfg = CFG_W'(5);
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 0 && m_wcnt == 0 && $urandom_range(3) == 0)
        depth_cfg = CFG_W'($urandom_range(12, 1));
      dimensionality = 3'($urandom_range(NDIM, 1));
      starting_addr  = CFG_W'($urandom);
      for (int d = 0; d < NDIM; d++) begin
        cfg_stride[d] = CFG_W'($urandom_range(100));
        cfg_range[d]  = CFG_W'($urandom_range(3, 1));
      end
      bus.wen_in  = ($urandom_range(9) < 7);
      bus.ren_in  = ($urandom_range(9) < 7);
      bus.data_in = DATA_W'($urandom);
      clk_en      = ($urandom_range(9) != 0);
      flush       = ($urandom_range(199) == 0);
      tick();
      vectors++;
      if (state_out !== 2'(m_state) || bus.wr_ready !== (m_state != 2) ||
          bus.rd_ready !== (m_state != 0) || bus.valid_out !== m_valid ||
          (m_valid && bus.data_out !== DATA_W'(m_data))) begin
        errors++;
        $display("FAIL rand_cyc%0d: got st=%0d wr=%b rd=%b v=%b d=%0d, want st=%0d wr=%b rd=%b v=%b d=%0d",
                 c, state_out, bus.wr_ready, bus.rd_ready, bus.valid_out, bus.data_out,
                 m_state, m_state != 2, m_state != 0, m_valid, m_data);
      end
    end
    flush = 1'b0; clk_en = 1'b1; bus.wen_in = 1'b0; bus.ren_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want normal finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
    bus.wen_in = 1'b0; bus.ren_in = 1'b0; bus.data_in = '0;
    set_cfg(1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    test_reset();
    test_cube();
    test_transpose();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_zero();
    test_reset_mid();
    test_clk_en();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
